// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core: one shared memory port, register file, ALU and a
// control FSM. Illegal or misaligned operations park the core in a sticky trap.
module multicycle_core #(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] pc,
    output logic             retire,
    output logic             trap,
    output logic [3:0]       dbg_state
);

    localparam int RIDX = (NREGS == 16) ? 4 : 5;
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] oldpc, a, b, aluout, mdr;
    logic [31:0]      ir;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_j;
    assign imm_i = {{(WIDTH-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{(WIDTH-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic is_lw, is_sw, is_r, is_i, is_beq, is_jal, reg_bad, illegal;
    always_comb begin
        is_lw   = (opcode == OP_LW) && (f3 == 3'b010);
        is_sw   = (opcode == OP_SW) && (f3 == 3'b010);
        is_r    = (opcode == OP_R) &&
                  (((f7 == 7'b0000000) && (f3 == 3'b000 || f3 == 3'b111 ||
                                           f3 == 3'b110 || f3 == 3'b010)) ||
                   ((f7 == 7'b0100000) && (f3 == 3'b000)));
        is_i    = (opcode == OP_I) &&
                  (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010);
        is_beq  = (opcode == OP_BEQ) && (f3 == 3'b000);
        is_jal  = (opcode == OP_JAL);
        // RV32E: only the register fields an instruction actually uses are range-checked.
        reg_bad = (NREGS == 16) &&
                  (((is_lw | is_sw | is_r | is_i | is_beq) && rs1[4]) ||
                   ((is_sw | is_r | is_beq) && rs2[4]) ||
                   ((is_lw | is_r | is_i | is_jal) && rd[4]));
        illegal = !(is_lw | is_sw | is_r | is_i | is_beq | is_jal) || reg_bad;
    end

    logic [WIDTH-1:0] rs1v, rs2v, alu_b, alu_res, addr_calc, jal_target;
    logic             jal_trap;
    assign rs1v       = (rs1 == 5'd0) ? '0 : rf[rs1[RIDX-1:0]];
    assign rs2v       = (rs2 == 5'd0) ? '0 : rf[rs2[RIDX-1:0]];
    assign alu_b      = (state == S_EXECI) ? imm_i : b;
    assign addr_calc  = a + (is_sw ? imm_s : imm_i);
    assign jal_target = oldpc + imm_j;
    assign jal_trap   = jal_target[1];

    always_comb begin
        case (f3)
            3'b111:  alu_res = a & alu_b;
            3'b110:  alu_res = a | alu_b;
            3'b010:  alu_res = ($signed(a) < $signed(alu_b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            default: alu_res = (state == S_EXECR && f7[5]) ? a - alu_b : a + alu_b;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_BOOT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_BOOT:     state_nx = S_FETCH;
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                if (illegal)              state_nx = S_TRAP;
                else if (is_lw || is_sw)  state_nx = S_MEMADR;
                else if (is_r)            state_nx = S_EXECR;
                else if (is_i)            state_nx = S_EXECI;
                else if (is_beq)          state_nx = S_BEQ;
                else                      state_nx = S_JAL;
            end
            S_MEMADR: begin
                if (addr_calc[1:0] != 2'b00) state_nx = S_TRAP;
                else if (is_lw)              state_nx = S_MEMREAD;
                else                         state_nx = S_MEMWRITE;
            end
            S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_nx = S_FETCH;
            S_EXECR, S_EXECI: state_nx = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_nx = S_FETCH;
            S_JAL:      state_nx = jal_trap ? S_TRAP : S_FETCH;
            S_TRAP:     state_nx = S_TRAP;
            default:    state_nx = S_BOOT;
        endcase
    end

    // Memory handshake: mem_req acts as valid and mem_ready as ready. A transfer
    // completes on the rising edge where both are high; until then mem_req,
    // mem_we, mem_addr and mem_wdata hold because they depend only on state and
    // registers that do not change while waiting.
    logic             rf_we;
    logic [WIDTH-1:0] rf_wd;
    always_comb begin
        mem_req   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
        mem_we    = (state == S_MEMWRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == S_FETCH)                                 mem_addr = pc;
        else if (state == S_MEMREAD || state == S_MEMWRITE)   mem_addr = aluout;
        if (state == S_MEMWRITE)                              mem_wdata = b;
        retire    = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                    ((state == S_JAL) && !jal_trap) || ((state == S_MEMWRITE) && mem_ready);
        trap      = (state == S_TRAP);
        rf_we     = ((state == S_MEMWB) || (state == S_ALUWB) ||
                     ((state == S_JAL) && !jal_trap)) && (rd != 5'd0);
        rf_wd     = aluout;
        if (state == S_MEMWB)    rf_wd = mdr;
        else if (state == S_JAL) rf_wd = oldpc + FOUR;
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[rd[RIDX-1:0]] <= rf_wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            oldpc  <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata[31:0];
                    oldpc <= pc;
                    pc    <= pc + FOUR;
                end
                S_DECODE: begin
                    a      <= rs1v;
                    b      <= rs2v;
                    aluout <= oldpc + imm_b;
                end
                S_MEMADR:         aluout <= addr_calc;
                S_MEMREAD:        if (mem_ready) mdr <= mem_rdata;
                S_EXECR, S_EXECI: aluout <= alu_res;
                S_BEQ:            if (a == b) pc <= aluout;
                S_JAL:            if (!jal_trap) pc <= jal_target;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: a wait-state memory model, directed programs for the
// control corners, and table plus random ALU vectors checked against a reference.
module tb_multicycle_core;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0] dbg_state;

  multicycle_core #(.WIDTH(32), .NREGS(16), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .retire(retire), .trap(trap),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model and monitor ----------------
  logic [31:0] mem [0:1023];
  int wait_n = 0;
  int wcnt = 0;
  int ncyc = 0;
  int first_req = -1;
  int ret_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] st_a_q[$];
  logic [31:0] st_d_q[$];
  bit hold_v = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic h_we;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (mem_req) begin
        if (wcnt >= wait_n) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[11:2]];
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hDEADBEEF;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
      #1;
      if (reset) begin
        ret_q.delete(); rd_q.delete(); st_a_q.delete(); st_d_q.delete();
        first_req = -1;
        hold_v = 1'b0;
      end else begin
        if (mem_req && first_req < 0) first_req = ncyc;
        if (retire) ret_q.push_back(ncyc);
        if (trap) check("no_retire_in_trap", 32'(retire), 32'd0);
        if (mem_req && mem_ready) begin
          if (mem_we) begin
            st_a_q.push_back(mem_addr);
            st_d_q.push_back(mem_wdata);
          end else begin
            rd_q.push_back(mem_addr);
          end
        end
        if (mem_req && hold_v) begin
          check("hold_addr", mem_addr, h_addr);
          check("hold_we", 32'(mem_we), 32'(h_we));
          check("hold_wdata", mem_wdata, h_wdata);
        end
        if (mem_req && !mem_ready) begin
          hold_v = 1'b1;
          h_addr = mem_addr;
          h_we = mem_we;
          h_wdata = mem_wdata;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- encoders and reference ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_S};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_B};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
  endfunction

  // op: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 andi, 7 ori, 8 slti
  function automatic logic [31:0] enc_alu(input int op, input logic [11:0] imm);
    case (op)
      0: return enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
      1: return enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);
      2: return enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3);
      3: return enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3);
      4: return enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);
      5: return enc_i(imm, 5'd1, 3'b000, 5'd3, OP_I);
      6: return enc_i(imm, 5'd1, 3'b111, 5'd3, OP_I);
      7: return enc_i(imm, 5'd1, 3'b110, 5'd3, OP_I);
      default: return enc_i(imm, 5'd1, 3'b010, 5'd3, OP_I);
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [11:0] imm);
    logic [31:0] y;
    y = (op >= 5) ? {{20{imm[11]}}, imm} : b;
    case (op)
      0, 5: return a + y;
      1:    return a - y;
      2, 6: return a & y;
      3, 7: return a | y;
      default: return ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[11:2]] = w;
  endtask

  task automatic prog_begin();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic prog_go();
    @(negedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic run_retires(input int n, input int budget);
    int c = 0;
    while (ret_q.size() < n && !trap && c < budget) begin
      @(negedge clk);
      c++;
    end
    #2;
    check("retire_count_reached", 32'(ret_q.size() >= n), 32'd1);
  endtask

  task automatic run_trap(input int budget);
    int c = 0;
    while (!trap && c < budget) begin
      @(negedge clk);
      c++;
    end
    #2;
    check("trap_set", 32'(trap), 32'd1);
  endtask

  task automatic check_store(input int idx, input logic [31:0] addr, input logic [31:0] data,
                             input string name);
    if (st_a_q.size() > idx) begin
      check({name, "_addr"}, st_a_q[idx], addr);
      check({name, "_data"}, st_d_q[idx], data);
    end else begin
      check({name, "_present"}, 32'(st_a_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_trap_held(input int exp_retires, input string name);
    repeat (10) @(negedge clk);
    #2;
    check({name, "_trap_held"}, 32'(trap), 32'd1);
    check({name, "_req_low"}, 32'(mem_req), 32'd0);
    check({name, "_retires"}, 32'(ret_q.size()), 32'(exp_retires));
  endtask

  task automatic run_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] imm, input logic [31:0] exp, input string name);
    prog_begin();
    put(32'h100, enc_i(12'h200, 5'd0, 3'b010, 5'd1, OP_LW));
    put(32'h104, enc_i(12'h204, 5'd0, 3'b010, 5'd2, OP_LW));
    put(32'h108, enc_alu(op, imm));
    put(32'h10C, enc_s(12'h208, 5'd3, 5'd0));
    put(32'h110, enc_b(13'd0, 5'd0, 5'd0));
    put(32'h200, a);
    put(32'h204, b);
    prog_go();
    run_retires(4, 100);
    check_store(0, 32'h208, exp, name);
  endtask

  typedef struct {
    int op;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[15];

  initial begin
    int c;
    vt[0]  = '{0, 32'd7,          32'd8,          12'h000, 32'd15};
    vt[1]  = '{1, 32'd5,          32'd7,          12'h000, 32'hFFFFFFFE};
    vt[2]  = '{2, 32'h0000F0F0,   32'h0000FF00,   12'h000, 32'h0000F000};
    vt[3]  = '{3, 32'h0000F0F0,   32'h00000F00,   12'h000, 32'h0000FFF0};
    vt[4]  = '{4, 32'hFFFFFFFF,   32'd1,          12'h000, 32'd1};
    vt[5]  = '{4, 32'd1,          32'hFFFFFFFF,   12'h000, 32'd0};
    vt[6]  = '{4, 32'h80000000,   32'h7FFFFFFF,   12'h000, 32'd1};
    vt[7]  = '{0, 32'hFFFFFFFF,   32'd1,          12'h000, 32'd0};
    vt[8]  = '{5, 32'd5,          32'd0,          12'hFFD, 32'd2};
    vt[9]  = '{6, 32'h000000FF,   32'd0,          12'h00F, 32'h0000000F};
    vt[10] = '{7, 32'h00000100,   32'd0,          12'h7FF, 32'h000007FF};
    vt[11] = '{8, 32'hFFFFFFFB,   32'd0,          12'hFFC, 32'd1};
    vt[12] = '{8, 32'd3,          32'd0,          12'hFFF, 32'd0};
    vt[13] = '{6, 32'h12345678,   32'd0,          12'hFFF, 32'h12345678};
    vt[14] = '{5, 32'h7FFFFFFF,   32'd0,          12'h001, 32'h80000000};

    // Reset values and the arithmetic program with zero-wait memory.
    wait_n = 0;
    prog_begin();
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_pc", pc, 32'h100);
    put(32'h100, enc_i(12'd5,   5'd0, 3'b000, 5'd1, OP_I));
    put(32'h104, enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OP_I));
    put(32'h108, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    put(32'h10C, enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd4));
    put(32'h110, enc_s(12'h040, 5'd3, 5'd0));
    put(32'h114, enc_s(12'h044, 5'd4, 5'd0));
    put(32'h118, enc_i(12'd7,   5'd0, 3'b000, 5'd0, OP_I));
    put(32'h11C, enc_s(12'h04C, 5'd0, 5'd0));
    put(32'h120, enc_b(13'd0, 5'd0, 5'd0));
    prog_go();
    #2;
    check("boot_no_req", 32'(mem_req), 32'd0);
    run_retires(8, 200);
    if (rd_q.size() > 0) check("first_fetch_addr", rd_q[0], 32'h100);
    else check("first_fetch_present", 32'(rd_q.size()), 32'd1);
    if (ret_q.size() >= 8) begin
      check("addi_cycles", 32'(ret_q[0] - first_req + 1), 32'd4);
      for (int i = 0; i < 7; i++) check("retire_spacing", 32'(ret_q[i+1] - ret_q[i]), 32'd4);
    end
    check_store(0, 32'h40, 32'd2, "sw_sum");
    check_store(1, 32'h44, 32'd1, "sw_slt");
    check_store(2, 32'h4C, 32'd0, "sw_x0");

    // Load and store with three wait states on every access.
    wait_n = 3;
    prog_begin();
    put(32'h100, enc_i(12'h040, 5'd0, 3'b010, 5'd5, OP_LW));
    put(32'h104, enc_s(12'h048, 5'd5, 5'd0));
    put(32'h108, enc_b(13'd0, 5'd0, 5'd0));
    put(32'h040, 32'd2);
    prog_go();
    run_retires(2, 200);
    if (ret_q.size() >= 2) begin
      check("lw_wait_cycles", 32'(ret_q[0] - first_req + 1), 32'd11);
      check("sw_wait_cycles", 32'(ret_q[1] - ret_q[0]), 32'd10);
    end
    check_store(0, 32'h48, 32'd2, "lw_wait");
    wait_n = 0;

    // beq taken at 0x20, then jal x1,-8 at 0x30.
    prog_begin();
    put(32'h100, enc_j(21'h1FFF20, 5'd0));
    put(32'h020, enc_b(13'd16, 5'd0, 5'd0));
    put(32'h030, enc_j(21'h1FFFF8, 5'd1));
    put(32'h028, enc_s(12'h050, 5'd1, 5'd0));
    put(32'h02C, enc_b(13'd0, 5'd0, 5'd0));
    prog_go();
    run_retires(5, 200);
    if (rd_q.size() >= 5) begin
      check("tk_fetch0", rd_q[0], 32'h100);
      check("tk_fetch1", rd_q[1], 32'h020);
      check("tk_fetch2", rd_q[2], 32'h030);
      check("tk_fetch3", rd_q[3], 32'h028);
      check("tk_fetch4", rd_q[4], 32'h02C);
    end else check("tk_fetch_count", 32'(rd_q.size()), 32'd5);
    if (ret_q.size() >= 2) check("beq_cycles", 32'(ret_q[1] - ret_q[0]), 32'd3);
    check_store(0, 32'h50, 32'h34, "jal_link");

    // beq not taken at 0x20.
    prog_begin();
    put(32'h100, enc_i(12'd1, 5'd0, 3'b000, 5'd6, OP_I));
    put(32'h104, enc_j(21'h1FFF1C, 5'd0));
    put(32'h020, enc_b(13'd16, 5'd6, 5'd0));
    put(32'h024, enc_s(12'h054, 5'd6, 5'd0));
    put(32'h028, enc_b(13'd0, 5'd0, 5'd0));
    prog_go();
    run_retires(5, 200);
    if (rd_q.size() >= 5) begin
      check("nt_fetch2", rd_q[2], 32'h020);
      check("nt_fetch3", rd_q[3], 32'h024);
      check("nt_fetch4", rd_q[4], 32'h028);
    end else check("nt_fetch_count", 32'(rd_q.size()), 32'd5);
    check_store(0, 32'h54, 32'd1, "nt_store");

    // Misaligned load traps and leaves its destination untouched.
    prog_begin();
    put(32'h100, enc_i(12'd9,   5'd0, 3'b000, 5'd7, OP_I));
    put(32'h104, enc_i(12'h042, 5'd0, 3'b010, 5'd7, OP_LW));
    prog_go();
    run_trap(60);
    check_trap_held(1, "misalign");
    prog_begin();
    put(32'h100, enc_s(12'h060, 5'd7, 5'd0));
    put(32'h104, enc_b(13'd0, 5'd0, 5'd0));
    prog_go();
    run_retires(1, 60);
    check_store(0, 32'h60, 32'd9, "misalign_rd_kept");

    // Illegal opcode, then a register index beyond the RV32E file.
    prog_begin();
    put(32'h100, 32'hFFFFFFFF);
    prog_go();
    run_trap(60);
    check_trap_held(0, "illegal_op");
    prog_begin();
    put(32'h100, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd17));
    prog_go();
    run_trap(60);
    check_trap_held(0, "rv32e_rd17");

    // Reset asserted while a store waits on memory.
    wait_n = 6;
    prog_begin();
    put(32'h100, enc_s(12'h040, 5'd0, 5'd0));
    put(32'h104, enc_b(13'd0, 5'd0, 5'd0));
    prog_go();
    c = 0;
    while (!(mem_req && mem_we) && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("reached_store_wait", 32'(mem_req && mem_we), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_req_drop", 32'(mem_req), 32'd0);
    check("async_pc", pc, 32'h100);
    check("no_store_before_reset", 32'(st_a_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    wait_n = 0;
    prog_go();
    run_retires(1, 60);
    if (rd_q.size() > 0) check("restart_fetch", rd_q[0], 32'h100);
    else check("restart_fetch_present", 32'(rd_q.size()), 32'd1);
    check_store(0, 32'h40, 32'd0, "restart_store");

    // Table vectors, then random vectors against the reference model.
    for (int i = 0; i < 15; i++) run_alu(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].exp, "alu_table");
    for (int i = 0; i < 30; i++) begin
      int op;
      logic [31:0] a, b;
      logic [11:0] imm;
      op  = $urandom_range(0, 8);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = 12'($urandom_range(0, 4095));
      wait_n = $urandom_range(0, 2);
      run_alu(op, a, b, imm, ref_alu(op, a, b, imm), "alu_random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
